mem_responder: RTL and testbench

- Word-addressed 16-bit memory target; the responder side of the processor's memory bus.
- Accepts read/write requests from the processor's bus interface and serves them after a programmable wait-state count.
- Returns read data that the processor's data register captures while ack is high.
- Four-phase req/ack handshake; a single clock domain.

---
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed 16-bit memory target on a four-phase req/ack bus.
// Requests are captured in IDLE and served after WAIT_CYCLES wait states.
module mem_responder #(
  parameter int AW          = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  output logic          ack,
  output logic          busy
);

  // state  | meaning
  // IDLE   | waiting for req; captures addr/we/wdata when it arrives
  // WAIT   | counting wait states down to zero
  // ACCESS | single cycle: memory read or write, ack raised at its end
  // RESP   | ack held high until the initiator drops req

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam int         DEPTH     = 2 ** AW;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;

  logic [15:0]   mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  // Array has no reset; a reset edge landing on ACCESS suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_b && (state_q == S_ACCESS) && we_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = ack_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
          if (WAIT_CYCLES > 0) begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          rdata_d = mem_q[addr_q];
        end
        ack_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        // An early req drop lands here with req=0 and releases ack at once.
        if (!req) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboarded bench for mem_responder: one instance with two wait states and
// one with none, sharing clock and reset.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_b;

  logic        req_a, we_a, ack_a, busy_a;
  logic [8:0]  addr_a;
  logic [15:0] wdata_a, rdata_a;

  logic        req_b, we_b, ack_b, busy_b;
  logic [8:0]  addr_b;
  logic [15:0] wdata_b, rdata_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] model_mem [512];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  mem_responder #(.AW(9), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst_b(rst_b), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .ack(ack_a), .busy(busy_a)
  );

  mem_responder #(.AW(9), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst_b(rst_b), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .ack(ack_b), .busy(busy_b)
  );

  task automatic drive(input bit sel, input bit r, input bit w,
                       input logic [8:0] a, input logic [15:0] d);
    if (sel) begin
      req_b = r; we_b = w; addr_b = a; wdata_b = d;
    end else begin
      req_a = r; we_a = w; addr_a = a; wdata_a = d;
    end
  endtask

  // lat counts edges from the capture edge (1) up to the edge that raised ack.
  task automatic bus_xfer(input bit sel, input bit w, input logic [8:0] a,
                          input logic [15:0] d, input int hold,
                          output int lat, output logic [15:0] rd, output int hold_bad);
    bit seen;
    seen = 1'b0;
    lat = 0;
    hold_bad = 0;
    drive(sel, 1'b1, w, a, d);
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      seen = sel ? (ack_b === 1'b1) : (ack_a === 1'b1);
    end
    if (!seen) lat = -1;
    rd = sel ? rdata_b : rdata_a;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if ((sel ? ack_b : ack_a) !== 1'b1 || (sel ? rdata_b : rdata_a) !== rd) hold_bad++;
    end
    drive(sel, 1'b0, w, a, d);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    int ack_seen;
    ack_seen = 0;
    rst_b = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 9'h000, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 9'h000, 16'h0000);
    repeat (3) begin
      @(posedge clk); #1;
      if (ack_a !== 1'b0 || ack_b !== 1'b0) ack_seen++;
    end
    n_checks++;
    if (ack_seen === 0) n_pass++;
    else $display("FAIL reset_ack: ack high in %0d reset cycles, required 0", ack_seen);
    n_checks++;
    if (busy_a === 1'b0 && busy_b === 1'b0) n_pass++;
    else $display("FAIL reset_busy: busy_a=%b busy_b=%b, required 0", busy_a, busy_b);
    n_checks++;
    if (rdata_a === 16'h0000 && rdata_b === 16'h0000) n_pass++;
    else $display("FAIL reset_rdata: rdata_a=%h rdata_b=%h, required 0000", rdata_a, rdata_b);
    drive(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 9'h000, 16'h0000);
    rst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input bit sel, input logic [8:0] a, input logic [15:0] d,
                          input int exp_lat, input string name);
    int lat, hb;
    logic [15:0] rd;
    model_mem[a] = d;
    bus_xfer(sel, 1'b1, a, d, 0, lat, rd, hb);
    n_checks++;
    if (lat === exp_lat) n_pass++;
    else $display("FAIL %s_lat: ack after %0d edges, required %0d", name, lat, exp_lat);
  endtask

  task automatic do_read(input bit sel, input logic [8:0] a, input int exp_lat,
                         input string name);
    int lat, hb;
    logic [15:0] rd, exp;
    exp_q.push_back(model_mem[a]);
    bus_xfer(sel, 1'b0, a, 16'h0000, 0, lat, rd, hb);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat === exp_lat) n_pass++;
    else $display("FAIL %s_lat: ack after %0d edges, required %0d", name, lat, exp_lat);
    n_checks++;
    if (rd === exp) n_pass++;
    else $display("FAIL %s_data: rdata=%h, required %h", name, rd, exp);
  endtask

  task automatic test_write_read;
    do_write(1'b0, 9'h005, 16'hA5C3, 4, "w2_write");
    do_read(1'b0, 9'h005, 4, "w2_read");
  endtask

  task automatic test_wait0;
    do_write(1'b1, 9'h000, 16'h1357, 2, "w0_write0");
    do_read(1'b1, 9'h000, 2, "w0_read0");
    do_write(1'b1, 9'h1FF, 16'hFFFF, 2, "w0_write_last");
    do_read(1'b1, 9'h1FF, 2, "w0_read_last");
  endtask

  task automatic test_hold;
    int lat, hb;
    logic [15:0] rd, exp;
    exp_q.push_back(model_mem[9'h005]);
    bus_xfer(1'b0, 1'b0, 9'h005, 16'h0000, 10, lat, rd, hb);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd === exp && hb === 0) n_pass++;
    else $display("FAIL hold: rdata=%h unstable_cycles=%0d, required %h and 0", rd, hb, exp);
    n_checks++;
    if (ack_a === 1'b0 && busy_a === 1'b0) n_pass++;
    else $display("FAIL hold_release: ack=%b busy=%b, required 0 0", ack_a, busy_a);
    n_checks++;
    if (rdata_a === exp) n_pass++;
    else $display("FAIL hold_rdata_kept: rdata=%h, required %h", rdata_a, exp);
  endtask

  task automatic test_capture_isolation;
    int cyc;
    do_write(1'b0, 9'h0AA, 16'h5555, 4, "iso_seed");
    model_mem[9'h010] = 16'hBEEF;
    drive(1'b0, 1'b1, 1'b1, 9'h010, 16'hBEEF);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 9'h0AA, 16'h1234);
    cyc = 1;
    while (ack_a !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc === 4) n_pass++;
    else $display("FAIL iso_lat: ack after %0d edges, required 4", cyc);
    drive(1'b0, 1'b0, 1'b0, 9'h0AA, 16'h1234);
    @(posedge clk); #1;
    do_read(1'b0, 9'h010, 4, "iso_target");
    do_read(1'b0, 9'h0AA, 4, "iso_other");
  endtask

  task automatic test_early_drop;
    int cyc;
    logic [15:0] exp;
    exp_q.push_back(model_mem[9'h0AA]);
    drive(1'b0, 1'b1, 1'b0, 9'h0AA, 16'h0000);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000);
    cyc = 1;
    while (ack_a !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (cyc === 4 && rdata_a === exp) n_pass++;
    else $display("FAIL early_drop: ack after %0d edges rdata=%h, required 4 and %h", cyc, rdata_a, exp);
    @(posedge clk); #1;
    n_checks++;
    if (ack_a === 1'b0 && busy_a === 1'b0) n_pass++;
    else $display("FAIL early_drop_release: ack=%b busy=%b, required 0 0", ack_a, busy_a);
  endtask

  task automatic test_back_to_back;
    do_read(1'b1, 9'h1FF, 2, "b2b_first");
    do_read(1'b1, 9'h000, 2, "b2b_second");
    do_write(1'b0, 9'h033, 16'h0F0F, 4, "b2b_write");
    do_read(1'b0, 9'h033, 4, "b2b_raw");
  endtask

  task automatic test_reset_mid_wait;
    do_write(1'b0, 9'h020, 16'h0001, 4, "rst_seed");
    drive(1'b0, 1'b1, 1'b1, 9'h020, 16'h7777);
    @(posedge clk); #1;
    n_checks++;
    if (busy_a === 1'b1) n_pass++;
    else $display("FAIL rst_mid_busy: busy=%b, required 1", busy_a);
    drive(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000);
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    n_checks++;
    if (ack_a === 1'b0 && busy_a === 1'b0) n_pass++;
    else $display("FAIL rst_mid_state: ack=%b busy=%b, required 0 0", ack_a, busy_a);
    repeat (4) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (ack_a === 1'b0) n_pass++;
    else $display("FAIL rst_mid_no_ack: ack=%b, required 0", ack_a);
    do_read(1'b0, 9'h020, 4, "rst_mid_read");
  endtask

  initial begin
    rst_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 9'h000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 9'h000, 16'h0000);
    test_reset();
    test_write_read();
    test_wait0();
    test_hold();
    test_capture_isolation();
    test_early_drop();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
